spi_regbank: RTL

//  Parametrised SPI (mode 0) peripheral register bank; successor to the fixed 5-register write-only SPI block.

---
 rtl/spi_regbank_if.sv | 25 ++
 rtl/spi_regbank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank_if.sv
// SPI pin bundle for spi_regbank: the controller drives SCLK/COPI/nCS, and the
// peripheral returns CIPO together with its pad enable.
interface spi_regbank_if;
  logic SCLK;
  logic COPI;
  logic nCS;
  logic CIPO;
  logic cipo_oe;

  modport slave (
    input  SCLK,
    input  COPI,
    input  nCS,
    output CIPO,
    output cipo_oe
  );

  modport master (
    output SCLK,
    output COPI,
    output nCS,
    input  CIPO,
    input  cipo_oe
  );
endinterface

// File: rtl/spi_regbank.sv
// SPI mode-0 peripheral register bank: [RW][ADDR][DATA] frames write or read back
// NUM_REGS registers of DATA_W bits; aborted or out-of-range frames pulse frame_err.
module spi_regbank #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regbank_if.slave               spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic                       frame_err
);

  localparam int FL    = 1 + ADDR_W + DATA_W;
  localparam int CW    = $clog2(FL + 1);
  localparam int RW_W  = NUM_REGS * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
  endfunction

  function automatic logic [DATA_W-1:0] reg_sel(input logic [RW_W-1:0]   r,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_W'(i)) v = r[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  // Input synchronisers plus one edge-detect flop per control pin
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic                   sclk_dly_q,  sclk_dly_d;
  logic                   ncs_dly_q,   ncs_dly_d;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, ncs_fall;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.COPI};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  spi.nCS};
    sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
    ncs_dly_d   = ncs_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ncs_dly_q   <= ncs_dly_d;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;

  // Frame FSM, bit counter, input shifter and read-back shifter
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FL-1:0]     sh_q, sh_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              rd_q, rd_d;
  logic              commit_q, commit_d;
  logic              abort_err;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    out_d     = out_q;
    rd_d      = rd_q;
    commit_d  = 1'b0;
    abort_err = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A rise seen in the same cycle as the nCS fall is deliberately not counted
        if (ncs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          sh_d    = '0;
          rd_d    = 1'b0;
        end
      end

      CMD: begin
        if (ncs_s) begin
          state_d   = IDLE;
          abort_err = (cnt_q != '0);
        end else if (sclk_rise) begin
          sh_d  = {sh_q[FL-2:0], copi_s};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ADDR_W)) begin
            state_d = DATA;
            rd_d    = ~sh_d[ADDR_W];
            out_d   = (~sh_d[ADDR_W] && addr_ok(sh_d[ADDR_W-1:0]))
                      ? reg_sel(regs_flat, sh_d[ADDR_W-1:0]) : '0;
          end
        end
      end

      DATA: begin
        if (ncs_s) begin
          state_d   = IDLE;
          abort_err = 1'b1;
        end else if (sclk_rise) begin
          sh_d  = {sh_q[FL-2:0], copi_s};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(FL - 1)) begin
            state_d  = DONE;
            commit_d = 1'b1;
          end
        end else if (sclk_fall && (cnt_q > CW'(1 + ADDR_W))) begin
          // The fall right after the load keeps the MSB on CIPO for the first data rise
          out_d = {out_q[DATA_W-2:0], 1'b0};
        end
      end

      DONE: begin
        if (ncs_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      out_q    <= '0;
      rd_q     <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      out_q    <= out_d;
      rd_q     <= rd_d;
      commit_q <= commit_d;
    end
  end

  // Commit stage: one cycle after the final rise the full frame sits in sh_q
  logic [RW_W-1:0]     regs_q, regs_d;
  logic [NUM_REGS-1:0] wr_q, wr_d;
  logic                ferr_q, ferr_d;
  logic                f_rw;
  logic [ADDR_W-1:0]   f_addr;
  logic [DATA_W-1:0]   f_data;

  assign f_rw   = sh_q[FL-1];
  assign f_addr = sh_q[FL-2 -: ADDR_W];
  assign f_data = sh_q[DATA_W-1:0];

  always_comb begin
    regs_d = regs_q;
    wr_d   = '0;
    ferr_d = abort_err;
    if (commit_q) begin
      if (!addr_ok(f_addr)) begin
        ferr_d = 1'b1;
      end else if (f_rw) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (f_addr == ADDR_W'(i)) begin
            regs_d[i*DATA_W +: DATA_W] = f_data;
            wr_d[i]                    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      wr_q   <= '0;
      ferr_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wr_q   <= wr_d;
      ferr_q <= ferr_d;
    end
  end

  assign regs_flat   = regs_q;
  assign wr_pulse    = wr_q;
  assign frame_err   = ferr_q;
  assign spi.cipo_oe = (state_q == DATA) && rd_q;
  assign spi.CIPO    = spi.cipo_oe & out_q[DATA_W-1];

endmodule
